// File: rtl/dma_desc_scheduler.sv
// dma_desc_scheduler
// Arbitrates two transfer requesters round-robin and splits the granted transfer
// into block-mode descriptors that never cross a 2^MAX_LOG2 byte boundary. The block
// hands them to the DMA engine one at a time and sums the engine's completion
// byte counts. It reports the result to the owning requester, or aborts on request.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rN_req / rN_sys_addr /     requester N: request (held until rN_ack), system
//   rN_card_addr / rN_bcount   address, card address, total byte count
//   rN_ack / rN_done / rN_err  requester N pulses: accepted, finished, rejected/aborted
//   rN_status                  requester N final status, valid with rN_done, held after
//   abort_req                  pulse: abort the active transfer
//   desc_req / desc_ready      descriptor handshake with the engine
//   desc_ptr / desc_data       descriptor pointer (always 0) and block-mode descriptor
//   desc_abort / desc_abort_ack engine abort request and acknowledge
//   desc_done / desc_done_status completion level and status (bits [63:32] = bytes)
module dma_desc_scheduler #(
    parameter int unsigned MAX_LOG2 = 12
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         r0_req,
    input  logic [63:0]  r0_sys_addr,
    input  logic [63:0]  r0_card_addr,
    input  logic [31:0]  r0_bcount,
    output logic         r0_ack,
    output logic         r0_done,
    output logic [159:0] r0_status,
    output logic         r0_err,

    input  logic         r1_req,
    input  logic [63:0]  r1_sys_addr,
    input  logic [63:0]  r1_card_addr,
    input  logic [31:0]  r1_bcount,
    output logic         r1_ack,
    output logic         r1_done,
    output logic [159:0] r1_status,
    output logic         r1_err,

    input  logic         abort_req,

    output logic         desc_req,
    input  logic         desc_ready,
    output logic [31:0]  desc_ptr,
    output logic [255:0] desc_data,
    output logic         desc_abort,
    input  logic         desc_abort_ack,
    input  logic         desc_done,
    input  logic [159:0] desc_done_status
);

    localparam int unsigned AW = 64;
    localparam int unsigned BW = 32;
    localparam int unsigned SW = 160;
    localparam int unsigned DW = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_COLLECT,
        S_RESP,
        S_ABORT
    } state_t;

    state_t         state;
    logic           prio;          // 0: r0 wins a tie, 1: r1 wins a tie
    logic           owner;         // requester that owns the active transfer
    logic [AW-1:0]  sys_addr;
    logic [AW-1:0]  card_addr;
    logic [BW-1:0]  remaining;
    logic [BW-1:0]  num_desc;
    logic [BW-1:0]  num_done;
    logic [BW-1:0]  done_bcount;
    logic [SW-65:0] status_hi;     // latched completion status [159:64]
    logic [31:0]    status_lo;     // latched completion status [31:0]
    logic           done_q;

    logic [BW-1:0]  page_left_c;
    logic [BW-1:0]  xfer_c;
    logic           first_c;
    logic           last_c;
    logic           done_rise_c;
    logic           active_c;
    logic [BW-1:0]  num_done_next_c;
    logic           gnt_c;
    logic           gnt_idx_c;
    logic [AW-1:0]  gnt_sys_c;
    logic [AW-1:0]  gnt_card_c;
    logic [BW-1:0]  gnt_bcount_c;
    logic [DW-1:0]  desc_word_c;

    assign desc_ptr = '0;

    // Descriptor sizing, completion edge detect and round-robin grant selection
    always_comb begin
        page_left_c     = BW'(64'd1 << MAX_LOG2) - BW'(sys_addr[MAX_LOG2-1:0]);
        xfer_c          = (remaining < page_left_c) ? remaining : page_left_c;
        first_c         = (num_desc == '0);
        last_c          = (xfer_c == remaining);
        desc_word_c     = {64'd0, card_addr, sys_addr, xfer_c, 20'd0,
                           last_c, first_c, 9'd0, last_c};
        done_rise_c     = desc_done & ~done_q;
        active_c        = (state == S_ISSUE) || (state == S_HOLD) || (state == S_COLLECT);
        num_done_next_c = num_done + BW'(done_rise_c);

        // While an ack is visible the requester has not yet dropped its request,
        // so a zero-length reject must not be granted twice.
        gnt_c           = (r0_req | r1_req) & ~(r0_ack | r1_ack);
        gnt_idx_c       = (r0_req && r1_req) ? prio : r1_req;
        gnt_sys_c       = gnt_idx_c ? r1_sys_addr  : r0_sys_addr;
        gnt_card_c      = gnt_idx_c ? r1_card_addr : r0_card_addr;
        gnt_bcount_c    = gnt_idx_c ? r1_bcount    : r0_bcount;
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            sys_addr    <= '0;
            card_addr   <= '0;
            remaining   <= '0;
            num_desc    <= '0;
            num_done    <= '0;
            done_bcount <= '0;
            status_hi   <= '0;
            status_lo   <= '0;
            done_q      <= 1'b0;
            r0_ack      <= 1'b0;
            r0_done     <= 1'b0;
            r0_err      <= 1'b0;
            r0_status   <= '0;
            r1_ack      <= 1'b0;
            r1_done     <= 1'b0;
            r1_err      <= 1'b0;
            r1_status   <= '0;
            desc_req    <= 1'b0;
            desc_data   <= '0;
            desc_abort  <= 1'b0;
        end else begin
            r0_ack  <= 1'b0;
            r0_done <= 1'b0;
            r0_err  <= 1'b0;
            r1_ack  <= 1'b0;
            r1_done <= 1'b0;
            r1_err  <= 1'b0;
            done_q  <= desc_done;

            // Completions may overtake descriptor issue; count every rising edge
            if (active_c && done_rise_c) begin
                num_done    <= num_done_next_c;
                done_bcount <= done_bcount + desc_done_status[63:32];
                status_hi   <= desc_done_status[159:64];
                status_lo   <= desc_done_status[31:0];
            end

            unique case (state)
                S_IDLE: begin
                    if (gnt_c) begin
                        owner       <= gnt_idx_c;
                        prio        <= ~gnt_idx_c;
                        sys_addr    <= gnt_sys_c;
                        card_addr   <= gnt_card_c;
                        remaining   <= gnt_bcount_c;
                        num_desc    <= '0;
                        num_done    <= '0;
                        done_bcount <= '0;
                        if (gnt_idx_c) r1_ack <= 1'b1;
                        else           r0_ack <= 1'b1;
                        if (gnt_bcount_c == '0) begin
                            if (gnt_idx_c) r1_err <= 1'b1;
                            else           r0_err <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (abort_req) begin
                        desc_req   <= 1'b0;
                        desc_abort <= 1'b1;
                        state      <= S_ABORT;
                    end else if (desc_req && desc_ready) begin
                        desc_req  <= 1'b0;
                        sys_addr  <= sys_addr + AW'(xfer_c);
                        card_addr <= card_addr + AW'(xfer_c);
                        remaining <= remaining - xfer_c;
                        num_desc  <= num_desc + 32'd1;
                        state     <= S_HOLD;
                    end else if (!desc_req && !desc_ready) begin
                        // Only offer a descriptor while the engine reports not ready
                        desc_req  <= 1'b1;
                        desc_data <= desc_word_c;
                    end
                end

                S_HOLD: begin
                    if (abort_req) begin
                        desc_abort <= 1'b1;
                        state      <= S_ABORT;
                    end else begin
                        state <= (remaining != '0) ? S_ISSUE : S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (abort_req) begin
                        desc_abort <= 1'b1;
                        state      <= S_ABORT;
                    end else if (num_done_next_c == num_desc) begin
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (owner) begin
                        r1_done   <= 1'b1;
                        r1_status <= {status_hi, done_bcount, status_lo};
                    end else begin
                        r0_done   <= 1'b1;
                        r0_status <= {status_hi, done_bcount, status_lo};
                    end
                    state <= S_IDLE;
                end

                S_ABORT: begin
                    if (desc_abort_ack) begin
                        desc_abort <= 1'b0;
                        if (owner) r1_err <= 1'b1;
                        else       r0_err <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Randomized scoreboard bench for dma_desc_scheduler. The driver predicts each
// transfer's descriptor list, ack order and final response from the request alone
// and queues them; a monitor pops and compares whenever the DUT presents them.
module tb_dma_desc_scheduler;

    localparam int unsigned MAX_LOG2 = 12;
    localparam logic [63:0] PAGE     = 64'd1 << MAX_LOG2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         r0_req = 1'b0;
    logic [63:0]  r0_sys_addr = '0;
    logic [63:0]  r0_card_addr = '0;
    logic [31:0]  r0_bcount = '0;
    logic         r0_ack, r0_done, r0_err;
    logic [159:0] r0_status;
    logic         r1_req = 1'b0;
    logic [63:0]  r1_sys_addr = '0;
    logic [63:0]  r1_card_addr = '0;
    logic [31:0]  r1_bcount = '0;
    logic         r1_ack, r1_done, r1_err;
    logic [159:0] r1_status;
    logic         abort_req = 1'b0;
    logic         desc_req;
    logic         desc_ready = 1'b0;
    logic [31:0]  desc_ptr;
    logic [255:0] desc_data;
    logic         desc_abort;
    logic         desc_abort_ack = 1'b0;
    logic         desc_done = 1'b0;
    logic [159:0] desc_done_status = '0;

    dma_desc_scheduler #(.MAX_LOG2(MAX_LOG2)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_sys_addr(r0_sys_addr), .r0_card_addr(r0_card_addr),
        .r0_bcount(r0_bcount), .r0_ack(r0_ack), .r0_done(r0_done),
        .r0_status(r0_status), .r0_err(r0_err),
        .r1_req(r1_req), .r1_sys_addr(r1_sys_addr), .r1_card_addr(r1_card_addr),
        .r1_bcount(r1_bcount), .r1_ack(r1_ack), .r1_done(r1_done),
        .r1_status(r1_status), .r1_err(r1_err),
        .abort_req(abort_req),
        .desc_req(desc_req), .desc_ready(desc_ready), .desc_ptr(desc_ptr),
        .desc_data(desc_data), .desc_abort(desc_abort), .desc_abort_ack(desc_abort_ack),
        .desc_done(desc_done), .desc_done_status(desc_done_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sys;
        logic [63:0] card;
        logic [31:0] xfer;
        logic        first;
        logic        last;
    } desc_t;

    typedef struct {
        int          idx;
        bit          is_err;
        logic [31:0] bcount;
    } end_t;

    desc_t        exp_desc[$];
    end_t         exp_end[$];
    int           exp_ack[$];
    logic [31:0]  pend[$];          // accepted byte counts the engine still owes
    logic [159:0] eng_last = '0;    // status word of the engine's latest completion
    bit           hold_cpl = 1'b0;
    bit           fast_cpl = 1'b0;
    int           rr_ptr = 0;       // requester that wins a tie
    int           tests = 0;
    int           fails = 0;
    int           ends_seen = 0;
    int           accepts_seen = 0;
    int           req_cycles = 0;
    int           cyc_cnt = 0;
    int           ack_cyc[2];
    int           end_cyc[2];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: walk the transfer in page-bounded chunks with plain arithmetic
    task automatic plan(input int n, input logic [63:0] sys_in, input logic [63:0] card_in,
                        input logic [31:0] bc, input bit aborted);
        logic [63:0] sys, card, room;
        logic [31:0] rem;
        int k;
        desc_t d;
        end_t e;
        sys = sys_in; card = card_in; rem = bc; k = 0;
        while (rem != 0) begin
            room    = PAGE - (sys % PAGE);
            d.xfer  = (64'(rem) < room) ? rem : 32'(room);
            d.sys   = sys;
            d.card  = card;
            d.first = (k == 0);
            d.last  = (d.xfer == rem);
            exp_desc.push_back(d);
            sys  = sys + 64'(d.xfer);
            card = card + 64'(d.xfer);
            rem  = rem - d.xfer;
            k++;
        end
        e.idx = n; e.is_err = (bc == 0) || aborted; e.bcount = bc;
        exp_end.push_back(e);
        exp_ack.push_back(n);
    endtask

    task automatic drive_req(input int n, input logic [63:0] sys, input logic [63:0] card,
                             input logic [31:0] bc);
        int cyc;
        logic ak;
        @(posedge clk); #1;
        if (n == 0) begin
            r0_sys_addr = sys; r0_card_addr = card; r0_bcount = bc; r0_req = 1'b1;
        end else begin
            r1_sys_addr = sys; r1_card_addr = card; r1_bcount = bc; r1_req = 1'b1;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            ak = (n == 0) ? r0_ack : r1_ack;
        end while (!ak && cyc < 4000);
        if (!ak) check("ack_timeout", 256'(ak), 256'(1));
        @(posedge clk); #1;
        if (n == 0) r0_req = 1'b0;
        else        r1_req = 1'b0;
    endtask

    task automatic wait_ends(input int target);
        int cyc;
        cyc = 0;
        while (ends_seen < target && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (ends_seen < target) check("end_timeout", 256'(ends_seen), 256'(target));
    endtask

    task automatic run_one(input int n, input logic [63:0] sys, input logic [63:0] card,
                           input logic [31:0] bc);
        int target;
        plan(n, sys, card, bc, 1'b0);
        rr_ptr = 1 - n;
        target = ends_seen + 1;
        drive_req(n, sys, card, bc);
        wait_ends(target);
    endtask

    task automatic run_pair(input logic [63:0] s0, input logic [63:0] c0, input logic [31:0] b0,
                            input logic [63:0] s1, input logic [63:0] c1, input logic [31:0] b1);
        int target, w;
        w = rr_ptr;
        if (w == 0) begin
            plan(0, s0, c0, b0, 1'b0); plan(1, s1, c1, b1, 1'b0);
        end else begin
            plan(1, s1, c1, b1, 1'b0); plan(0, s0, c0, b0, 1'b0);
        end
        // the loser is granted last, so the winner has the tie next time
        rr_ptr = w;
        target = ends_seen + 2;
        fork
            drive_req(0, s0, c0, b0);
            drive_req(1, s1, c1, b1);
        join
        wait_ends(target);
        if (((w == 0) ? b0 : b1) != 0)
            check("loser_ack_after_winner_done", 256'(ack_cyc[1-w] - end_cyc[w]), 256'(1));
    endtask

    task automatic check_reset_outputs();
        check("rst_pulses", 256'({r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err,
                                  desc_req, desc_abort}), 256'(0));
        check("rst_desc_ptr", 256'(desc_ptr), 256'(0));
        check("rst_desc_data", desc_data, 256'(0));
        check("rst_r0_status", 256'(r0_status), 256'(0));
        check("rst_r1_status", 256'(r1_status), 256'(0));
    endtask

    // Engine model: random ready, one-cycle completion pulses carrying the byte count
    initial begin : engine
        bit phase;
        logic [31:0] x;
        logic [159:0] st;
        phase = 1'b0;
        forever begin
            @(posedge clk); #1;
            desc_ready = 1'($urandom_range(0, 1));
            if (phase) begin
                desc_done = 1'b0;
                phase = 1'b0;
            end else if (!hold_cpl && pend.size() > 0 && (fast_cpl || $urandom_range(0, 3) == 0)) begin
                x = pend.pop_front();
                st = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                st[63:32] = x;
                desc_done_status = st;
                eng_last = st;
                desc_done = 1'b1;
                phase = 1'b1;
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations
    initial begin : monitor
        desc_t d;
        end_t e;
        int xa;
        logic ak, dn, er, prev_req, prev_ready;
        logic [159:0] st;
        prev_req = 1'b0; prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (rst_n) begin
                if (desc_req) req_cycles++;
                if (desc_req && !prev_req)
                    check("req_rise_needs_ready_low", 256'(prev_ready), 256'(0));
                if (desc_req && desc_ready) begin
                    accepts_seen++;
                    pend.push_back(desc_data[63:32]);
                    if (exp_desc.size() == 0) begin
                        check("unexpected_desc", 256'(1), 256'(0));
                    end else begin
                        d = exp_desc.pop_front();
                        check("desc_data", desc_data, {64'd0, d.card, d.sys, d.xfer, 20'd0,
                                                       d.last, d.first, 9'd0, d.last});
                    end
                end
                for (int n = 0; n < 2; n++) begin
                    ak = (n == 0) ? r0_ack : r1_ack;
                    dn = (n == 0) ? r0_done : r1_done;
                    er = (n == 0) ? r0_err : r1_err;
                    st = (n == 0) ? r0_status : r1_status;
                    if (ak) begin
                        ack_cyc[n] = cyc_cnt;
                        if (exp_ack.size() == 0) begin
                            check("unexpected_ack", 256'(n + 1), 256'(0));
                        end else begin
                            xa = exp_ack.pop_front();
                            check("ack_order", 256'(n), 256'(xa));
                        end
                    end
                    if (dn || er) begin
                        ends_seen++;
                        end_cyc[n] = cyc_cnt;
                        if (exp_end.size() == 0) begin
                            check("unexpected_end", 256'({dn, er}), 256'(0));
                        end else begin
                            e = exp_end.pop_front();
                            check("end_requester", 256'(n), 256'(e.idx));
                            check("end_done_err", 256'({dn, er}), 256'({!e.is_err, e.is_err}));
                            if (e.bcount == 0)
                                check("zero_len_err_with_ack", 256'(ak), 256'(1));
                            if (dn)
                                check("done_status", 256'(st),
                                      256'({eng_last[159:64], e.bcount, eng_last[31:0]}));
                        end
                    end
                end
            end
            prev_req = desc_req;
            prev_ready = desc_ready;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required $finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int target, cyc, base, hits;
        logic [63:0] s, c, s2, c2;
        logic [31:0] b, b2;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous after reset: r0 single descriptor first, then r1 boundary split
        run_pair(64'h1000, 64'h0, 32'h100, 64'h0F00, 64'h8000, 32'h1200);

        // Zero length on r1: ack with err, no descriptor offered
        base = req_cycles;
        run_one(1, 64'h3000, 64'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("zero_len_no_desc_req", 256'(req_cycles - base), 256'(0));

        // Early completions while later descriptors are still being issued
        fast_cpl = 1'b1;
        run_one(0, 64'h0800, 64'h20, 32'h2800);
        run_one(1, 64'h0FFC, 64'h40, 32'h1008);
        fast_cpl = 1'b0;

        // abort_req in IDLE has no effect
        @(posedge clk); #1 abort_req = 1'b1;
        @(posedge clk); #1 abort_req = 1'b0;
        hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (desc_abort || desc_req || r0_err || r1_err) hits++;
        end
        check("abort_in_idle_ignored", 256'(hits), 256'(0));

        // Abort during COLLECT: desc_abort held until acknowledged, then rN_err
        hold_cpl = 1'b1;
        plan(0, 64'h0F00, 64'h5000, 32'h1200, 1'b1);
        rr_ptr = 1;
        target = ends_seen + 1;
        drive_req(0, 64'h0F00, 64'h5000, 32'h1200);
        cyc = 0;
        while (exp_desc.size() != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1 abort_req = 1'b1;
        @(posedge clk); #1 abort_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_held", 256'({desc_abort, desc_req, r0_err}), 256'(3'b100));
        end
        @(posedge clk); #1 desc_abort_ack = 1'b1;
        @(posedge clk); #1 desc_abort_ack = 1'b0;
        wait_ends(target);
        @(negedge clk);
        check("abort_released", 256'(desc_abort), 256'(0));
        pend.delete();
        hold_cpl = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            s  = {$urandom(), $urandom()};
            c  = {$urandom(), $urandom()};
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h2400));
            fast_cpl = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                s2 = {$urandom(), $urandom()};
                c2 = {$urandom(), $urandom()};
                b2 = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h2400));
                run_pair(s, c, b, s2, c2, b2);
            end else begin
                run_one(int'($urandom_range(0, 1)), s, c, b);
            end
        end
        fast_cpl = 1'b0;

        // Reset asserted while a descriptor is being offered
        plan(0, 64'h0, 64'h100, 32'h3000, 1'b0);
        rr_ptr = 1;
        drive_req(0, 64'h0, 64'h100, 32'h3000);
        cyc = 0;
        while (!desc_req && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (!desc_req) check("issue_timeout", 256'(desc_req), 256'(1));
        #2 rst_n = 1'b0;
        hold_cpl = 1'b1;
        #1 check_reset_outputs();
        exp_desc.delete();
        exp_end.delete();
        exp_ack.delete();
        pend.delete();
        desc_done = 1'b0;
        rr_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold_cpl = 1'b0;
        base = ends_seen;
        repeat (20) @(negedge clk);
        check("no_end_after_reset", 256'(ends_seen - base), 256'(0));

        // Round-robin pointer is back on r0 after reset
        run_pair(64'h7F80, 64'h1, 32'h180, 64'h2000, 64'h2, 32'h40);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
